// File: rtl/slave_mem_responder.sv
// slave_mem_responder
//   Single-lane slave endpoint for one crossbar slave port. Accepts read and
//   write requests on a req/ack handshake and answers them from a small
//   word-addressed memory. The ack can be delayed by a configurable number of
//   wait cycles. Read data returns through a fixed-latency pipeline as a
//   one-cycle resp pulse.
//
//   Parameters
//     AW       slave address width
//     DEPTH    memory words (power of two, >= 2)
//     ACK_WAIT extra wait cycles before ack (0..15)
//     RD_LAT   cycles from read acceptance to the resp pulse (1..8)
//
//   Ports
//     clk    sole clock, rising edge
//     rst    asynchronous active-high reset
//     req    request, held high until accepted
//     cmd    1 = write, 0 = read
//     addr   word address (wraps modulo DEPTH)
//     wdata  write data
//     ack    registered; transfer accepted at an edge where req & ack
//     resp   registered one-cycle read-response pulse
//     rdata  registered read data, zero whenever resp is low
module slave_mem_responder #(
  parameter int AW       = 30,
  parameter int DEPTH    = 16,
  parameter int ACK_WAIT = 0,
  parameter int RD_LAT   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          cmd,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ack,
  output logic          resp,
  output logic [31:0]   rdata
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [IW-1:0] idx;
  logic          accept;
  logic          rd_acc;
  logic          wr_acc;

  logic [31:0]   mem   [DEPTH];
  logic          vld_p [RD_LAT];
  logic [31:0]   dat_p [RD_LAT];

  // Upper address bits select nothing: the address space wraps modulo DEPTH.
  assign idx = addr[IW-1:0];

  if (AW > IW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[AW-1:IW];
  end

  // ack is a register that is high exactly while the FSM sits in ACK, so the
  // accepting edge is simply one where ack and req coincide.
  assign accept = ack & req;
  assign rd_acc = accept & ~cmd;
  assign wr_acc = accept & cmd;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (ACK_WAIT > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(ACK_WAIT);
          end else begin
            state_nxt = ACK;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          // Master withdrew before being served; abandon the wait.
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nxt = ACK;
          end
        end
      end
      ACK: begin
        // One ack cycle only; a missing req here is a master protocol
        // violation and nothing is accepted.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= (state_nxt == ACK);
    end
  end

  // Backing memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (wr_acc) begin
      mem[idx] <= wdata;
    end
  end

  // Read pipeline stage p0: the sample is taken from mem before any write at
  // this edge, and non-read slots carry zero so rdata idles at zero.
  // Stages p1..p(RD_LAT-1) are a plain shift; the last stage drives outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        vld_p[k] <= 1'b0;
        dat_p[k] <= 32'h0;
      end
    end else begin
      vld_p[0] <= rd_acc;
      dat_p[0] <= rd_acc ? mem[idx] : 32'h0;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        dat_p[k] <= dat_p[k-1];
      end
    end
  end

  assign resp  = vld_p[RD_LAT-1];
  assign rdata = dat_p[RD_LAT-1];

endmodule

// File: tb/tb_slave_mem_responder.sv
module tb_slave_mem_responder;

  logic        clk;
  logic        rst;
  logic [3:0]  req_v;
  logic        cmd;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  ack_v;
  logic [3:0]  resp_v;
  logic [31:0] rdata_v [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sel      = 0;

  // Per-instance configuration, matching the instantiations below.
  int aw_of [4] = '{0, 3, 0, 0};
  int rl_of [4] = '{2, 2, 4, 8};

  // Reference memory per instance and the read scoreboard.
  logic [31:0] model [4][16];
  logic [31:0] exp_data_q [$];
  int          exp_cyc_q  [$];

  slave_mem_responder #(.AW(30), .DEPTH(16), .ACK_WAIT(0), .RD_LAT(2)) u0 (
    .clk(clk), .rst(rst), .req(req_v[0]), .cmd(cmd), .addr(addr), .wdata(wdata),
    .ack(ack_v[0]), .resp(resp_v[0]), .rdata(rdata_v[0]));
  slave_mem_responder #(.AW(30), .DEPTH(16), .ACK_WAIT(3), .RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .cmd(cmd), .addr(addr), .wdata(wdata),
    .ack(ack_v[1]), .resp(resp_v[1]), .rdata(rdata_v[1]));
  slave_mem_responder #(.AW(30), .DEPTH(16), .ACK_WAIT(0), .RD_LAT(4)) u2 (
    .clk(clk), .rst(rst), .req(req_v[2]), .cmd(cmd), .addr(addr), .wdata(wdata),
    .ack(ack_v[2]), .resp(resp_v[2]), .rdata(rdata_v[2]));
  slave_mem_responder #(.AW(30), .DEPTH(16), .ACK_WAIT(0), .RD_LAT(8)) u3 (
    .clk(clk), .rst(rst), .req(req_v[3]), .cmd(cmd), .addr(addr), .wdata(wdata),
    .ack(ack_v[3]), .resp(resp_v[3]), .rdata(rdata_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic clear_model();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 16; i++)
        model[s][i] = 32'h0;
    exp_data_q.delete();
    exp_cyc_q.delete();
  endtask

  // Issue one transfer on instance sel. Must be called just after a rising
  // edge. Checks the ack latency and records the expected read result.
  task automatic do_xfer(input bit wr, input logic [29:0] a, input logic [31:0] d,
                         input bit hold);
    int n;
    bit got;
    cmd = wr;
    addr = a;
    wdata = d;
    req_v[sel] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack_v[sel]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ack_timeout: inst %0d addr %h no ack within %0d cycles", sel, a, n);
      req_v[sel] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    if (n != aw_of[sel] + 2) begin
      failures++;
      $display("FAIL ack_latency: inst %0d got %0d cycles expected %0d", sel, n, aw_of[sel] + 2);
    end
    @(posedge clk); #1;
    if (wr) begin
      model[sel][a[3:0]] = d;
    end else begin
      exp_data_q.push_back(model[sel][a[3:0]]);
      exp_cyc_q.push_back(cyc + rl_of[sel] - 1);
    end
    if (!hold) req_v[sel] = 1'b0;
  endtask

  // Watch instance sel for a fixed window, popping the scoreboard on every
  // resp pulse. Ends just after a rising edge.
  task automatic collect(input int n, input int window, input string name);
    int got;
    bit unexp;
    bit bad_idle;
    logic [31:0] d;
    int c;
    got = 0;
    unexp = 1'b0;
    bad_idle = 1'b0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (resp_v[sel]) begin
        if (exp_data_q.size() == 0) begin
          unexp = 1'b1;
        end else begin
          d = exp_data_q.pop_front();
          c = exp_cyc_q.pop_front();
          got++;
          checks++;
          if (rdata_v[sel] !== d) begin
            failures++;
            $display("FAIL %s_rdata: got %h expected %h", name, rdata_v[sel], d);
          end
          checks++;
          if (cyc != c) begin
            failures++;
            $display("FAIL %s_resp_cycle: got %0d expected %0d", name, cyc, c);
          end
        end
      end else if (rdata_v[sel] !== 32'h0) begin
        bad_idle = 1'b1;
      end
    end
    checks++;
    if (got != n || unexp) begin
      failures++;
      $display("FAIL %s_count: got %0d resp (unexpected=%0d) expected %0d", name, got, unexp, n);
    end
    checks++;
    if (bad_idle) begin
      failures++;
      $display("FAIL %s_rdata_idle: rdata nonzero while resp low, expected 0", name);
    end
    exp_data_q.delete();
    exp_cyc_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit got;
    #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (ack_v[s] !== 1'b0 || resp_v[s] !== 1'b0 || rdata_v[s] !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs: inst %0d ack=%b resp=%b rdata=%h expected 0/0/0",
                 s, ack_v[s], resp_v[s], rdata_v[s]);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    sel = 0;
    do_xfer(1'b1, 30'd5, 32'h12345678, 1'b0);
    do_xfer(1'b0, 30'd5, 32'h0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_v[0]) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || rdata_v[0] !== 32'h12345678) begin
      failures++;
      $display("FAIL pre_reset_read: resp=%b rdata=%h expected 1/12345678", got, rdata_v[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (resp_v[0] !== 1'b0 || rdata_v[0] !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_resp: resp=%b rdata=%h expected 0/0", resp_v[0], rdata_v[0]);
    end
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
    cmd = 1'b0;
    addr = 30'd5;
    req_v[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack_v[0]) begin
        got = 1'b1;
        break;
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!got || ack_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_ack: ack seen=%b ack after rst=%b expected 1/0", got, ack_v[0]);
    end
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_xfer(1'b0, 30'd5, 32'h0, 1'b0);
    collect(1, 6, "read_after_reset");
  endtask

  task automatic test_write_read();
    sel = 0;
    do_xfer(1'b1, 30'd3, 32'hDEADBEEF, 1'b0);
    collect(0, 5, "write_no_resp");
    do_xfer(1'b0, 30'd3, 32'h0, 1'b0);
    collect(1, 6, "write_read");
  endtask

  task automatic test_wait_states();
    bit saw_ack;
    sel = 1;
    do_xfer(1'b1, 30'd9, 32'hCAFE0001, 1'b0);
    cmd = 1'b0;
    addr = 30'd9;
    req_v[1] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    req_v[1] = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack_v[1]) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin
      failures++;
      $display("FAIL wait_abort: ack=1 after req dropped, expected 0");
    end
    @(posedge clk); #1;
    do_xfer(1'b0, 30'd9, 32'h0, 1'b0);
    collect(1, 6, "wait_read");
  endtask

  task automatic test_wrap();
    sel = 0;
    do_xfer(1'b1, 30'h13, 32'h00000011, 1'b0);
    do_xfer(1'b0, 30'h03, 32'h0, 1'b0);
    collect(1, 6, "wrap");
  endtask

  task automatic test_pipelined();
    sel = 2;
    do_xfer(1'b1, 30'd1, 32'h0000000A, 1'b0);
    do_xfer(1'b1, 30'd2, 32'h0000000B, 1'b0);
    do_xfer(1'b1, 30'd3, 32'h0000000C, 1'b0);
    fork
      begin
        do_xfer(1'b0, 30'd1, 32'h0, 1'b1);
        do_xfer(1'b0, 30'd2, 32'h0, 1'b1);
        do_xfer(1'b0, 30'd3, 32'h0, 1'b0);
      end
      collect(3, 20, "pipe3");
    join
    fork
      begin
        do_xfer(1'b0, 30'd2, 32'h0, 1'b1);
        do_xfer(1'b1, 30'd2, 32'h000000FF, 1'b0);
      end
      collect(1, 16, "read_before_write");
    join
    do_xfer(1'b0, 30'd2, 32'h0, 1'b0);
    collect(1, 10, "read_after_write");
  endtask

  task automatic test_reset_inflight();
    sel = 3;
    do_xfer(1'b1, 30'd7, 32'h00000055, 1'b0);
    do_xfer(1'b0, 30'd7, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
    collect(0, 12, "inflight_discard");
    do_xfer(1'b0, 30'd7, 32'h0, 1'b0);
    collect(1, 12, "inflight_mem_cleared");
  endtask

  initial begin
    rst = 1'b0;
    req_v = 4'b0;
    cmd = 1'b0;
    addr = 30'd0;
    wdata = 32'h0;
    clear_model();
    #2 rst = 1'b1;
    test_reset();
    test_write_read();
    test_wait_states();
    test_wrap();
    test_pipelined();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
